gpio_scan_ctrl: RTL
===================

Name: gpio_scan_ctrl

Overview:
Sequencer for the board GPIO bring-up test. It walks a test pattern across the GPIO banks one bank at a time and holds all non-selected banks at a programmable idle value. This makes shorts and miswired bits between banks visible on a scope or LED board. It sits between the PLL lock output and the top-level gpio bank pins, and replaces the free-running counter drive.

Parameters:
NUM_BANKS, 26, number of 8-bit GPIO banks driven (gpio, gpioa..gpioy)
BANK_W, 8, bits per bank; also the number of sub-steps per bank
DWELL_W, 24, width of the dwell timer

Ports:
clk  input  1  system clock (PLL output)
resetn  input  1  asynchronous active-low reset
pll_LOCKED  input  1  PLL lock; low = clock not trustworthy
start  input  1  level; sampled each cycle; starts a scan from IDLE
stop  input  1  level; aborts the scan without done
mode  input  2  pattern select, sampled at start
dwell  input  DWELL_W  cycles per sub-step minus 1, sampled at start
idle_val  input  BANK_W  value for non-selected banks, sampled at start
gpio_out  output  NUM_BANKS*BANK_W  bank k occupies bits [k*BANK_W +: BANK_W]
bank_sel  output  5  index of the active bank
sub_idx  output  3  current sub-step within the bank
busy  output  1  high in DRIVE
step_pulse  output  1  one-cycle pulse at each sub-step advance
done  output  1  one-cycle pulse at completion
lock_err  output  1  sticky; set when lock is lost during a scan; cleared on next accepted start

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE.
  - gpio_out, bank_sel, sub_idx, busy, step_pulse, done and lock_err are all 0.
  - Captured idle value is 0.
- States: IDLE, DRIVE, DONE.
- IDLE -> DRIVE on start=1 && pll_LOCKED=1 && stop=0. On that edge:
  - capture mode, dwell and idle_val.
  - bank=0, sub=0, timer=dwell, lock_err cleared.
- start while busy is ignored. start with pll_LOCKED=0 is ignored and does not set lock_err.
- DRIVE:
  - If timer!=0, timer decrements.
  - If timer==0, timer reloads to dwell, step_pulse=1, and:
    - if sub<BANK_W-1: sub++.
    - else if bank<NUM_BANKS-1: bank++, sub=0.
    - else: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. gpio_out returns to all-idle in DONE.
- Each sub-step lasts dwell+1 cycles. A full scan is NUM_BANKS*BANK_W*(dwell+1) cycles in DRIVE. dwell=0 means 1 cycle per sub-step.
- stop=1 in DRIVE: go to IDLE next edge, with no done and no step_pulse. stop has priority over a simultaneous timer expiry.
- pll_LOCKED=0 in DRIVE or DONE: go to IDLE next edge and set lock_err. Lock loss has priority over stop.
- Pattern for the active bank (sub = s, bank = b):
  - mode 00, walking one: 1<<s.
  - mode 01, walking zero: ~(1<<s).
  - mode 10, alternating: 0xFF when s is even, 0x00 when s is odd.
  - mode 11, bank id: b zero-extended, held constant for all s.
- gpio_out:
  - Registered. It reflects the state/bank/sub of the same clock edge, with no extra lag; bank_sel and sub_idx change on the same edge.
  - Active bank = pattern; all other banks = captured idle_val.
  - In IDLE every bank = captured idle_val, which is 0 after reset.
- bank and sub arithmetic never wraps: terminal values trigger the advance or DONE. bank_sel stays fixed at its last value after abort, until the next start.

Decomposition:
- Package gpio_test_pkg holds:
  - state enum (IDLE, DRIVE, DONE)
  - mode encodings (MODE_WALK1, MODE_WALK0, MODE_ALT, MODE_BANKID)
  - default NUM_BANKS and BANK_W constants
- Sub-module gpio_pattern_gen: combinational (mode, sub, bank) -> BANK_W pattern. The controller owns the FSM, the timer and the bank replication/mux register.

Test Plan:
1. Reset, then pll_LOCKED=1, mode=00, dwell=0, idle_val=0x00, pulse start -> busy rises next edge with bank 0 = 0x01. Over 208 cycles the bank/sub sequence is 0x01,0x02..0x80 per bank, bank 25 last. Then one done pulse and gpio_out all 0x00.
2. mode=11, dwell=3, idle_val=0xA5 -> each bank shows its index (bank 25 = 0x19) for 32 cycles. All others read 0xA5, and step_pulse fires every 4 cycles.
3. mode=01, dwell=0; assert stop at cycle 20 -> IDLE next edge with no done. gpio_out all idle_val, and bank_sel stays at 2.
4. Drop pll_LOCKED mid-scan in DRIVE -> IDLE next edge and lock_err=1. A following start with lock high clears lock_err and restarts at bank 0.
5. stop and timer expiry in the same cycle -> no step_pulse, IDLE. Lock loss and stop in the same cycle -> lock_err=1.
6. start held high continuously with dwell=0 -> done pulse, 1 cycle in IDLE, then a new scan begins. Assert resetn low mid-scan -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/gpio_test_pkg.sv
// Shared types and default sizes for the GPIO bring-up scan sequencer.
package gpio_test_pkg;

    localparam int DEF_NUM_BANKS = 26;
    localparam int DEF_BANK_W    = 8;
    localparam int DEF_DWELL_W   = 24;
    localparam int SEL_W         = 5;
    localparam int SUB_W         = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_WALK1  = 2'b00,
        MODE_WALK0  = 2'b01,
        MODE_ALT    = 2'b10,
        MODE_BANKID = 2'b11
    } mode_e;

endpackage

// File: rtl/gpio_scan_ctrl_if.sv
// Control/status bundle between the bring-up test host and the scan sequencer.
interface gpio_scan_if
    import gpio_test_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int BANK_W    = DEF_BANK_W,
    parameter int DWELL_W   = DEF_DWELL_W
);
    logic                        start;
    logic                        stop;
    logic [1:0]                  mode;
    logic [DWELL_W-1:0]          dwell;
    logic [BANK_W-1:0]           idle_val;
    logic [NUM_BANKS*BANK_W-1:0] gpio_out;
    logic [SEL_W-1:0]            bank_sel;
    logic [SUB_W-1:0]            sub_idx;
    logic                        busy;
    logic                        step_pulse;
    logic                        done;
    logic                        lock_err;

    modport master (
        output start, stop, mode, dwell, idle_val,
        input  gpio_out, bank_sel, sub_idx, busy, step_pulse, done, lock_err
    );

    modport slave (
        input  start, stop, mode, dwell, idle_val,
        output gpio_out, bank_sel, sub_idx, busy, step_pulse, done, lock_err
    );
endinterface

// File: rtl/gpio_pattern_gen.sv
// Combinational test pattern for the active bank, chosen by mode, sub-step and bank index.
module gpio_pattern_gen
    import gpio_test_pkg::*;
#(
    parameter int BANK_W = DEF_BANK_W
) (
    input  mode_e              mode,
    input  logic [SUB_W-1:0]   sub,
    input  logic [SEL_W-1:0]   bank,
    output logic [BANK_W-1:0]  pattern
);
    logic [BANK_W-1:0] one_hot;

    assign one_hot = BANK_W'(1) << sub;

    always_comb begin
        pattern = '0;
        case (mode)
            MODE_WALK1:  pattern = one_hot;
            MODE_WALK0:  pattern = ~one_hot;
            MODE_ALT:    pattern = sub[0] ? '0 : '1;
            MODE_BANKID: pattern = BANK_W'(bank);
            default:     pattern = '0;
        endcase
    end
endmodule

// File: rtl/gpio_scan_ctrl.sv
// Walks a test pattern across the GPIO banks one at a time, holding the rest at a captured idle value.
module gpio_scan_ctrl
    import gpio_test_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int BANK_W    = DEF_BANK_W,
    parameter int DWELL_W   = DEF_DWELL_W
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          pll_LOCKED,
    gpio_scan_if.slave    bus
);
    state_e                      state, state_d;
    mode_e                       mode_q, mode_d;
    logic [SEL_W-1:0]            bank, bank_d;
    logic [SUB_W-1:0]            sub, sub_d;
    logic [DWELL_W-1:0]          timer, timer_d;
    logic [DWELL_W-1:0]          dwell_q, dwell_d;
    logic [BANK_W-1:0]           idle_q, idle_d;
    logic [BANK_W-1:0]           pattern;
    logic [NUM_BANKS*BANK_W-1:0] gpio_q, gpio_d;
    logic                        step_q, step_d;
    logic                        lock_err_q, lock_err_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            mode_q     <= MODE_WALK1;
            bank       <= '0;
            sub        <= '0;
            timer      <= '0;
            dwell_q    <= '0;
            idle_q     <= '0;
            gpio_q     <= '0;
            step_q     <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            state      <= state_d;
            mode_q     <= mode_d;
            bank       <= bank_d;
            sub        <= sub_d;
            timer      <= timer_d;
            dwell_q    <= dwell_d;
            idle_q     <= idle_d;
            gpio_q     <= gpio_d;
            step_q     <= step_d;
            lock_err_q <= lock_err_d;
        end
    end

    // Lock loss outranks stop, and stop outranks a timer expiry in the same cycle.
    always_comb begin
        state_d    = state;
        mode_d     = mode_q;
        bank_d     = bank;
        sub_d      = sub;
        timer_d    = timer;
        dwell_d    = dwell_q;
        idle_d     = idle_q;
        step_d     = 1'b0;
        lock_err_d = lock_err_q;
        case (state)
            IDLE: begin
                if (bus.start && pll_LOCKED && !bus.stop) begin
                    state_d    = DRIVE;
                    mode_d     = mode_e'(bus.mode);
                    dwell_d    = bus.dwell;
                    idle_d     = bus.idle_val;
                    timer_d    = bus.dwell;
                    bank_d     = '0;
                    sub_d      = '0;
                    lock_err_d = 1'b0;
                end
            end
            DRIVE: begin
                if (!pll_LOCKED) begin
                    state_d    = IDLE;
                    lock_err_d = 1'b1;
                end else if (bus.stop) begin
                    state_d = IDLE;
                end else if (timer != '0) begin
                    timer_d = timer - DWELL_W'(1);
                end else begin
                    timer_d = dwell_q;
                    step_d  = 1'b1;
                    if (sub != SUB_W'(BANK_W - 1)) begin
                        sub_d = sub + SUB_W'(1);
                    end else if (bank != SEL_W'(NUM_BANKS - 1)) begin
                        bank_d = bank + SEL_W'(1);
                        sub_d  = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!pll_LOCKED) begin
                    lock_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    gpio_pattern_gen #(.BANK_W(BANK_W)) u_pattern (
        .mode    (mode_d),
        .sub     (sub_d),
        .bank    (bank_d),
        .pattern (pattern)
    );

    // Built from next-state values so the pins change on the same edge as bank_sel/sub_idx.
    always_comb begin
        gpio_d = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (state_d == DRIVE && bank_d == SEL_W'(k)) begin
                gpio_d[k*BANK_W +: BANK_W] = pattern;
            end else begin
                gpio_d[k*BANK_W +: BANK_W] = idle_d;
            end
        end
    end

    assign bus.gpio_out   = gpio_q;
    assign bus.bank_sel   = bank;
    assign bus.sub_idx    = sub;
    assign bus.busy       = (state == DRIVE);
    assign bus.done       = (state == DONE);
    assign bus.step_pulse = step_q;
    assign bus.lock_err   = lock_err_q;
endmodule
